// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, FSM state type and grant type for the writeback arbiter.
package rf_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    typedef enum logic {EMPTY, FULL} state_t;
    typedef enum logic {GNT_ALU, GNT_MEM} gnt_t;
endpackage

// File: rtl/rf_fwd_cmp.sv
// rf_fwd_cmp: one forwarding compare of a read index against the pending write index.
module rf_fwd_cmp #(
    parameter int ADDR_W = 5
) (
    input  logic              vld,
    input  logic [ADDR_W-1:0] rd_idx,
    input  logic [ADDR_W-1:0] st_idx,
    output logic              hit
);
    assign hit = vld && rd_idx == st_idx && rd_idx != '0;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin ALU/load writeback arbiter with a one-entry output stage.
// Forwarding compares are built only when RF_WB_FWD_EN is defined.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              btn,
    input  logic              Rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_idx,
    input  logic [DATA_W-1:0] alu_dat,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_idx,
    input  logic [DATA_W-1:0] mem_dat,
    output logic              mem_ready,
    input  logic              wr_hold,
    output logic [ADDR_W-1:0] regW,
    output logic [DATA_W-1:0] Wdat,
    output logic              RegWrite,
    input  logic [ADDR_W-1:0] rd_idx_a,
    input  logic [ADDR_W-1:0] rd_idx_b,
    input  logic [ADDR_W-1:0] rd_idx_c,
    output logic              fwd_hit_a,
    output logic              fwd_hit_b,
    output logic              fwd_hit_c,
    output logic [DATA_W-1:0] fwd_dat,
    output logic [15:0]       wb_cnt
);
    state_t            state_q, state_d;
    gnt_t              last_q, last_d;
    logic [ADDR_W-1:0] idx_q, idx_d, x_idx;
    logic [DATA_W-1:0] dat_q, dat_d, x_dat;
    logic [15:0]       cnt_q, cnt_d;
    logic              full, can_acc, gnt_alu, gnt_mem, xfer, load;

    // Outputs are gated by Rst_n so nothing handshakes or commits while reset is held.
    always_comb begin
        full      = Rst_n && state_q == FULL;
        RegWrite  = full && !wr_hold;
        can_acc   = Rst_n && (state_q == EMPTY || RegWrite);
        gnt_alu   = alu_valid && (!mem_valid || last_q == GNT_MEM);
        gnt_mem   = mem_valid && !gnt_alu;
        alu_ready = can_acc && gnt_alu;
        mem_ready = can_acc && gnt_mem;
        xfer      = alu_ready || mem_ready;
        x_idx     = alu_ready ? alu_idx : mem_idx;
        x_dat     = alu_ready ? alu_dat : mem_dat;
        load      = xfer && x_idx != '0;
        state_d   = load ? FULL : (RegWrite ? EMPTY : state_q);
        idx_d     = load ? x_idx : (RegWrite ? '0 : idx_q);
        dat_d     = load ? x_dat : (RegWrite ? '0 : dat_q);
        last_d    = xfer ? (alu_ready ? GNT_ALU : GNT_MEM) : last_q;
        cnt_d     = cnt_q + {15'd0, RegWrite};
        regW      = full ? idx_q : '0;
        Wdat      = full ? dat_q : '0;
        wb_cnt    = cnt_q;
    end

    always_ff @(posedge btn) begin
        if (!Rst_n) begin
            state_q <= EMPTY;
            last_q  <= GNT_MEM;
            idx_q   <= '0;
            dat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef RF_WB_FWD_EN
    rf_fwd_cmp #(.ADDR_W(ADDR_W)) u_cmp_a (.vld(full), .rd_idx(rd_idx_a), .st_idx(idx_q), .hit(fwd_hit_a));
    rf_fwd_cmp #(.ADDR_W(ADDR_W)) u_cmp_b (.vld(full), .rd_idx(rd_idx_b), .st_idx(idx_q), .hit(fwd_hit_b));
    rf_fwd_cmp #(.ADDR_W(ADDR_W)) u_cmp_c (.vld(full), .rd_idx(rd_idx_c), .st_idx(idx_q), .hit(fwd_hit_c));
    assign fwd_dat = dat_q;
`else
    logic unused_rd;
    assign unused_rd = ^{rd_idx_a, rd_idx_b, rd_idx_c};
    assign fwd_hit_a = 1'b0;
    assign fwd_hit_b = 1'b0;
    assign fwd_hit_c = 1'b0;
    assign fwd_dat   = '0;
`endif
endmodule
